seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits on the FPGA board display.
- Holds a displayed word (e.g. PC or a debug register) and drives one nibble per dwell slot to the decoder.
- Drives the matching active-low digit select.
- Inserts an all-off guard gap between digits to prevent ghosting.
- Accepts new values through a valid/ready handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (>=2)
PRESCALE, 50000, clk cycles each digit is lit (>=1)
GUARD, 16, clk cycles all digits off between slots (>=0; 0 = no gap state)

Ports:
clk  in  1  system clock; one clock domain
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = scan display; 0 = display dark
blank_lz  in  1  1 = blank leading-zero digits
load_valid  in  1  new display value offered
load_ready  out  1  block can accept load_data
load_data  in  4*NUM_DIGITS  value; nibble i feeds digit i (digit 0 = LS nibble)
digit_sel  out  NUM_DIGITS  one-hot active-low digit enable; all ones = dark
nibble  out  4  hex value for the shared decoder
blank  out  1  1 = top level forces all segments off
frame_done  out  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset values (rst sampled high on clk edge):
  - state=IDLE, idx=0, dwell counter=0
  - active=0, shadow=0, pending=0
  - digit_sel=all ones, nibble=0, blank=1, load_ready=1, frame_done=0
- Reset mid-scan or mid-handshake has the same effect; any pending value is discarded.
- All outputs are registered and reflect state one cycle after the causing edge.
- Handshake:
  - Transfer occurs when load_valid & load_ready on a clk edge.
  - load_ready = ~pending.
  - The accepted value goes to shadow and sets pending.
  - load_data is ignored when load_ready=0; a producer holds valid until accepted.
- Shadow to active transfer:
  - In IDLE: on the cycle after pending sets.
  - In scan states: only at the frame boundary (the wrap from digit NUM_DIGITS-1 to 0).
  - A transfer clears pending; load_ready rises the next cycle.
  - A load accepted in the same cycle as a boundary becomes pending and applies at the following boundary.
- FSM:
  - IDLE:
    - digit_sel all ones, blank=1.
    - enable=1 -> SCAN with idx=0, counter=0.
  - SCAN:
    - digit_sel bit idx low, nibble=active[4*idx+:4], blank=lz(idx).
    - counter counts to PRESCALE-1.
    - Then -> GAP if GUARD>0; otherwise advance idx and stay in SCAN.
  - GAP:
    - digit_sel all ones, blank=1.
    - counter counts to GUARD-1, then advance idx -> SCAN.
  - Advance:
    - idx = (idx==NUM_DIGITS-1) ? 0 : idx+1.
    - The wrap is the frame boundary: frame_done=1 for exactly that cycle.
    - Frame length = NUM_DIGITS*(PRESCALE+GUARD) cycles.
  - enable=0 in any scan state:
    - -> IDLE next edge; the display goes dark with no partial slot completion.
    - No frame_done is issued.
    - Re-enable always restarts at digit 0.
- Leading-zero rule lz(i):
  - 1 iff blank_lz=1, i!=0, and active nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - blank_lz is sampled live each slot.
- Counter widths: clog2(PRESCALE) / clog2(GUARD) bits, minimum 1; no overflow beyond the terminal count.

Decomposition:
- Shared package: FSM state encoding (IDLE, SCAN, GAP) and a clog2 helper function.
- One natural sub-module: seg7_lz_mask. It is combinational and maps an active word plus blank_lz to a per-digit blank vector.
- The existing shared hex decoder stays instantiated at top level, fed by nibble; its output is gated by blank and digit_sel.

Test Plan:
(Bench config: NUM_DIGITS=4, PRESCALE=3, GUARD=1.)
- Reset, then enable=1, load 0x1234 while idle:
  - active=0x1234 two cycles after accept.
  - Slots show nibble 4,3,2,1 with digit_sel 1110,1101,1011,0111, each lit 3 cycles, separated by 1-cycle 1111.
  - frame_done pulses every 16 cycles.
- Mid-frame load of 0xABCD during digit 1:
  - Remainder of the frame still shows 2,1.
  - load_ready=0 until the boundary; the next frame shows D,C,B,A.
  - A second valid offered while pending is not accepted.
- blank_lz=1 with active=0x0050:
  - blank=1 on digits 3 and 2; digits 1 and 0 show 5 and 0 unblanked.
  - active=0x0000 -> only digit 0 shown.
- enable dropped during digit 2 SCAN:
  - digit_sel=1111 next cycle; no frame_done.
  - Re-enable -> digit 0 first.
- rst asserted while pending=1 in SCAN:
  - All outputs at reset values next cycle; load_ready=1; shadow value never displayed.
- GUARD=0 variant: digit_sel transitions directly 1110->1101 with no all-ones cycle; frame_done every 12 cycles.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and elaboration helpers for the multiplexed 7-segment scanner.
// Holds the scan FSM encoding and the width helpers used to size the counters.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Ceiling log2. Returns 0 for values 0 and 1; callers clamp to a 1-bit minimum.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// Leading-zero blanking mask: digit i is blanked when blanking is requested,
// it is not digit 0, and every nibble from i up to the top digit is zero.
module seg7_lz_mask
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] word_i,
  input  logic                    blank_lz_i,
  output logic [NUM_DIGITS-1:0]   mask_o
);

  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] mask;

  // Walk from the most significant digit downwards, accumulating "all zero so far".
  always_comb begin
    upper_zero = 1'b1;
    mask       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (word_i[4*i +: 4] == 4'h0);
      mask[i]    = blank_lz_i & (i != 0) & upper_zero;
    end
  end

  assign mask_o = mask;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scanner for NUM_DIGITS common-anode digits sharing one hex
// decoder, with an all-off guard gap between slots and frame-aligned updates.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    blank_lz,
  // Handshake: a word transfers on any clk edge where load_valid and load_ready
  // are both 1. load_ready is low while a word waits in the shadow register;
  // load_data is ignored otherwise and the producer keeps load_valid asserted.
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              nibble,
  output logic                    blank,
  output logic                    frame_done,
  output state_t                  dbg_state
);

  localparam int IDX_W = max2(clog2(NUM_DIGITS), 1);
  localparam int CNT_W = max2(max2(clog2(PRESCALE), clog2(GUARD)), 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] G_LAST   = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam bit               HAS_GAP  = (GUARD > 0);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    blank_q, blank_d;
  logic                    load_ready_q, load_ready_d;
  logic                    frame_done_q, frame_done_d;

  logic                    accept;
  logic                    advance;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   lz_mask;

  // Blanking is evaluated on the word that will be on display after this edge.
  seg7_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lz_mask (
    .word_i     (active_d),
    .blank_lz_i (blank_lz),
    .mask_o     (lz_mask)
  );

  assign accept = load_valid & ~pending_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    advance   = 1'b0;
    wrap      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
        if (enable) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == P_LAST) begin
          cnt_d = '0;
          if (HAS_GAP) begin
            state_d = ST_GAP;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == G_LAST) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // A waiting word only replaces the active one on the frame wrap, so every
    // frame shows digits from a single word.
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (accept) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    digit_sel_d  = '1;
    nibble_d     = 4'h0;
    blank_d      = 1'b1;
    frame_done_d = wrap;
    load_ready_d = ~pending_d;
    if (state_d == ST_SCAN) begin
      digit_sel_d[idx_d] = 1'b0;
      nibble_d           = active_d[{idx_d, 2'b00} +: 4];
      blank_d            = lz_mask[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      digit_sel_q  <= '1;
      nibble_q     <= 4'h0;
      blank_q      <= 1'b1;
      load_ready_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      digit_sel_q  <= digit_sel_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      load_ready_q <= load_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_sel  = digit_sel_q;
  assign nibble     = nibble_q;
  assign blank      = blank_q;
  assign load_ready = load_ready_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a GUARD=1 and a GUARD=0 instance share stimulus and
// are compared every cycle against a frame-timeline model of the display.
module tb_seg7_scan_ctrl;
  import seg7_scan_ctrl_pkg::*;

  localparam int N = 4;
  localparam int P = 3;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic [15:0] load_data;

  logic        rdy_a, rdy_b;
  logic [3:0]  sel_a, sel_b;
  logic [3:0]  nib_a, nib_b;
  logic        blk_a, blk_b;
  logic        fd_a, fd_b;
  state_t      st_a, st_b;

  int errors;
  int checks;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (rdy_a),
    .load_data  (load_data),
    .digit_sel  (sel_a),
    .nibble     (nib_a),
    .blank      (blk_a),
    .frame_done (fd_a),
    .dbg_state  (st_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .GUARD(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_ready (rdy_b),
    .load_data  (load_data),
    .digit_sel  (sel_b),
    .nibble     (nib_b),
    .blank      (blk_b),
    .frame_done (fd_b),
    .dbg_state  (st_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state, index 0 = GUARD 1, index 1 = GUARD 0
  bit          m_scan [2];
  int          m_t    [2];
  logic [15:0] m_act  [2];
  logic [15:0] m_sh   [2];
  bit          m_pend [2];
  bit          m_rst  [2];
  logic [3:0]  e_sel  [2];
  logic [3:0]  e_nib  [2];
  logic        e_blank[2];
  logic        e_fd   [2];
  logic        e_rdy  [2];
  logic        e_lit  [2];
  logic [1:0]  e_st   [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Display is a timeline: t counts cycles since scanning began, each slot is
  // P lit cycles plus the guard, and a frame is N slots.
  task automatic model_step(input int k);
    int          g, slot_len, frame_len, pos, slot;
    bit          acc;
    logic [15:0] sh;
    g         = (k == 0) ? 1 : 0;
    slot_len  = P + g;
    frame_len = N * slot_len;
    if (rst) begin
      m_scan[k] = 0; m_t[k] = 0; m_act[k] = '0; m_sh[k] = '0; m_pend[k] = 0; m_rst[k] = 1;
      e_sel[k] = 4'hF; e_nib[k] = 4'h0; e_blank[k] = 1'b1; e_fd[k] = 1'b0;
      e_rdy[k] = 1'b1; e_lit[k] = 1'b0; e_st[k] = ST_IDLE;
      return;
    end
    m_rst[k] = 0;
    acc      = load_valid && !m_pend[k];
    e_fd[k]  = 1'b0;
    if (!m_scan[k]) begin
      if (m_pend[k]) begin
        m_act[k] = m_sh[k]; m_pend[k] = 0;
      end
      if (enable) begin
        m_scan[k] = 1; m_t[k] = 0;
      end
    end else if (!enable) begin
      m_scan[k] = 0;
    end else begin
      m_t[k]++;
      if (m_t[k] % frame_len == 0) begin
        e_fd[k] = 1'b1;
        if (m_pend[k]) begin
          m_act[k] = m_sh[k]; m_pend[k] = 0;
        end
      end
    end
    if (acc) begin
      m_sh[k] = load_data; m_pend[k] = 1;
    end
    e_rdy[k] = !m_pend[k];
    e_sel[k] = 4'hF; e_nib[k] = 4'h0; e_blank[k] = 1'b1; e_lit[k] = 1'b0; e_st[k] = ST_IDLE;
    if (m_scan[k]) begin
      pos  = m_t[k] % frame_len;
      slot = pos / slot_len;
      if (pos % slot_len < P) begin
        sh             = m_act[k] >> (4 * slot);
        e_lit[k]       = 1'b1;
        e_sel[k][slot] = 1'b0;
        e_nib[k]       = sh[3:0];
        e_blank[k]     = blank_lz && (slot != 0) && (sh == 16'h0);
        e_st[k]        = ST_SCAN;
      end else begin
        e_st[k] = ST_GAP;
      end
    end
  endtask

  task automatic compare(input int k);
    logic [3:0] s, n;
    logic       b, f, r;
    logic [1:0] st;
    if (k == 0) begin
      s = sel_a; n = nib_a; b = blk_a; f = fd_a; r = rdy_a; st = st_a;
    end else begin
      s = sel_b; n = nib_b; b = blk_b; f = fd_b; r = rdy_b; st = st_b;
    end
    chk($sformatf("digit_sel[g%0d]", 1 - k), s, e_sel[k]);
    chk($sformatf("blank[g%0d]", 1 - k), b, e_blank[k]);
    chk($sformatf("frame_done[g%0d]", 1 - k), f, e_fd[k]);
    chk($sformatf("load_ready[g%0d]", 1 - k), r, e_rdy[k]);
    chk($sformatf("state[g%0d]", 1 - k), st, e_st[k]);
    if (e_lit[k] || m_rst[k]) chk($sformatf("nibble[g%0d]", 1 - k), n, e_nib[k]);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #2;
    for (int k = 0; k < 2; k++) compare(k);
  endtask

  task automatic send(input logic [15:0] data);
    int n;
    n = 0;
    while (!(rdy_a && rdy_b) && n < 64) begin
      tick(); n++;
    end
    chk("send_ready_timeout", {31'b0, rdy_a & rdy_b}, 32'd1);
    load_valid = 1'b1;
    load_data  = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_sel_a(input logic [3:0] target, input string tag);
    int n;
    n = 0;
    while (sel_a !== target && n < 64) begin
      tick(); n++;
    end
    chk(tag, sel_a, target);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; enable = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = '0;

    // reset values
    tick(); tick();
    chk("rst_sel", sel_a, 4'hF);
    chk("rst_blank", blk_a, 1'b1);
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_nibble", nib_a, 4'h0);
    rst = 1'b0;

    // load while idle, then scan a few frames
    send(16'h1234);
    tick();
    enable = 1'b1;
    repeat (40) tick();

    // mid-frame load during digit 1, then a second offer while pending
    wait_sel_a(4'b1101, "reach_digit1");
    load_valid = 1'b1; load_data = 16'hABCD;
    tick();
    load_data = 16'h9999;
    tick(); tick();
    chk("ready_low_while_pending", rdy_a, 1'b0);
    load_valid = 1'b0;
    repeat (36) tick();

    // leading-zero blanking
    blank_lz = 1'b1;
    send(16'h0050);
    repeat (40) tick();
    send(16'h0000);
    repeat (40) tick();
    blank_lz = 1'b0;
    send(16'h5A0F);
    repeat (20) tick();

    // enable dropped during digit 2
    wait_sel_a(4'b1011, "reach_digit2");
    enable = 1'b0;
    tick();
    chk("disable_dark", sel_a, 4'hF);
    chk("disable_no_fd", fd_a, 1'b0);
    repeat (3) tick();
    enable = 1'b1;
    tick();
    chk("reenable_digit0", sel_a, 4'b1110);
    repeat (20) tick();

    // reset while a word is pending
    wait_sel_a(4'b1110, "reach_digit0");
    load_valid = 1'b1; load_data = 16'h7777;
    tick();
    load_valid = 1'b0;
    tick();
    chk("pending_before_rst", rdy_a, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_mid_sel", sel_a, 4'hF);
    chk("rst_mid_ready", rdy_a, 1'b1);
    chk("rst_mid_fd", fd_a, 1'b0);
    rst = 1'b0;
    repeat (40) tick();

    // randomized phase
    for (int i = 0; i < 700; i++) begin
      rst        = ($urandom_range(0, 249) == 0);
      enable     = ($urandom_range(0, 24) != 0);
      blank_lz   = $urandom_range(0, 1);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'h00F0) : 16'($urandom);
      tick();
    end
    rst = 1'b0; load_valid = 1'b0;
    tick();

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
